// File: rtl/irq_out.sv
// Interrupt output stage: turns the controller's one-cycle irq strobe into an
// active-low board interrupt. Pulse mode (WIDTH+1 cycles) or level mode (held
// until acknowledged), with a programmable minimum deasserted gap. Strobes
// that arrive while busy merge into one pending re-assertion and are counted.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | irq_n high, waiting for a strobe or a pending request
// S_ASSERT  | irq_n low; pulse timer in cnt, or waiting for acknowledge
// S_HOLDOFF | irq_n high, enforcing the minimum gap before re-assertion
module irq_out #(
    parameter logic [4:0] BASE_ADDR = 5'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       irq_in,
    output logic       irq_n
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       en;
    logic       mode;
    logic       pend;
    logic [7:0] width;
    logic [7:0] holdoff;
    logic [7:0] miss;

    logic [5:0] offs;
    logic       hit;
    logic       wr_ctrl;
    logic       wr_width;
    logic       wr_hold;
    logic       wr_miss;
    logic       busy_strobe;
    logic [7:0] miss_base;
    logic [7:0] miss_next;

    // Address decode; the extra top bit keeps addresses below the base from
    // wrapping into the window.
    always_comb begin
        offs     = {1'b0, csr_a} - {1'b0, BASE_ADDR};
        hit      = (offs[5:2] == 4'd0);
        wr_ctrl  = csr_we && hit && (offs[1:0] == 2'd0);
        wr_width = csr_we && hit && (offs[1:0] == 2'd1);
        wr_hold  = csr_we && hit && (offs[1:0] == 2'd2);
        wr_miss  = csr_we && hit && (offs[1:0] == 2'd3);
    end

    // Miss counter: a clear write lands first, then a busy strobe increments.
    always_comb begin
        busy_strobe = irq_in && en && (state != S_IDLE);
        miss_base   = wr_miss ? 8'h00 : miss;
        miss_next   = (busy_strobe && (miss_base != 8'hFF)) ? miss_base + 8'd1 : miss_base;
    end

    // CSR read mux.
    always_comb begin
        csr_do = 8'h00;
        if (hit) begin
            case (offs[1:0])
                2'd0:    csr_do = {(state == S_ASSERT), pend, 4'b0000, mode, en};
                2'd1:    csr_do = width;
                2'd2:    csr_do = holdoff;
                default: csr_do = miss;
            endcase
        end
    end

    // Register file, FSM and registered interrupt output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 8'h00;
            en      <= 1'b0;
            mode    <= 1'b0;
            pend    <= 1'b0;
            width   <= 8'h0F;
            holdoff <= 8'h00;
            miss    <= 8'h00;
            irq_n   <= 1'b1;
        end else begin
            if (wr_ctrl) begin
                en   <= csr_di[0];
                mode <= csr_di[1];
            end
            if (wr_width) width   <= csr_di;
            if (wr_hold)  holdoff <= csr_di;
            miss <= miss_next;

            if (!en) begin
                pend  <= 1'b0;
                state <= S_IDLE;
                irq_n <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (irq_in || pend) begin
                            state <= S_ASSERT;
                            cnt   <= width;
                            irq_n <= 1'b0;
                            pend  <= 1'b0;
                        end
                    end
                    S_ASSERT: begin
                        if (irq_in) pend <= 1'b1;
                        if (mode ? (wr_ctrl && csr_di[7]) : (cnt == 8'h00)) begin
                            irq_n <= 1'b1;
                            if (holdoff == 8'h00) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_HOLDOFF;
                                cnt   <= holdoff - 8'd1;
                            end
                        end else if (!mode) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    S_HOLDOFF: begin
                        if (cnt == 8'h00) begin
                            if (pend) begin
                                state <= S_ASSERT;
                                cnt   <= width;
                                irq_n <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                            pend <= irq_in;
                        end else begin
                            cnt <= cnt - 8'd1;
                            if (irq_in) pend <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        irq_n <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_out.sv
// Bench for irq_out: directed scenarios followed by randomized traffic, with a
// cycle-level behavioural model of the interrupt line and CSR contents.
module tb_irq_out;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] csr_a = 5'h0;
    logic [7:0] csr_di = 8'h00;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       irq_in = 1'b0;
    logic       irq_n;

    irq_out #(.BASE_ADDR(5'h0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .irq_in (irq_in),
        .irq_n  (irq_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model. phase: 0 = quiet, 1 = line asserted, 2 = enforced gap.
    int         m_phase = 0;
    int         m_timer = 0;
    bit         m_en = 0, m_mode = 0, m_pend = 0, m_irq_n = 1;
    int         m_width = 15, m_hold = 0, m_miss = 0;

    function automatic logic [7:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return {(m_phase == 1), m_pend, 4'b0000, m_mode, m_en};
            5'd1:    return 8'(m_width);
            5'd2:    return 8'(m_hold);
            5'd3:    return 8'(m_miss);
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_start();
        m_phase = 1;
        m_timer = m_width;
        m_irq_n = 0;
    endtask

    task automatic m_step(input bit irq, input bit we, input logic [4:0] a, input logic [7:0] di, input bit rst);
        bit done;
        bit had_pend;
        if (!rst) begin
            m_phase = 0; m_timer = 0; m_en = 0; m_mode = 0; m_pend = 0;
            m_irq_n = 1; m_width = 15; m_hold = 0; m_miss = 0;
            return;
        end
        if (we && a == 5'd3) m_miss = 0;
        if (m_en && irq && m_phase != 0 && m_miss < 255) m_miss++;
        if (!m_en) begin
            m_pend  = 0;
            m_phase = 0;
            m_irq_n = 1;
        end else if (m_phase == 0) begin
            if (irq || m_pend) begin
                m_start();
                m_pend = 0;
            end
        end else if (m_phase == 1) begin
            done = m_mode ? (we && a == 5'd0 && di[7]) : (m_timer == 0);
            if (irq) m_pend = 1;
            if (done) begin
                m_irq_n = 1;
                if (m_hold == 0) m_phase = 0;
                else begin
                    m_phase = 2;
                    m_timer = m_hold - 1;
                end
            end else if (!m_mode) begin
                m_timer--;
            end
        end else begin
            if (m_timer == 0) begin
                had_pend = m_pend;
                m_pend = 0;
                if (had_pend) m_start();
                else m_phase = 0;
            end else begin
                m_timer--;
            end
            if (irq) m_pend = 1;
        end
        if (we && a == 5'd0) begin m_en = di[0]; m_mode = di[1]; end
        if (we && a == 5'd1) m_width = int'(di);
        if (we && a == 5'd2) m_hold  = int'(di);
    endtask

    logic       obs_irq_n;
    logic [7:0] obs_do;

    // One clock cycle: drive, sample away from the edge, compare to the model,
    // then advance the model across the coming edge.
    task automatic tick(input bit irq, input bit we, input logic [4:0] a, input logic [7:0] di, input bit rst);
        @(negedge clk);
        rst_n = rst; irq_in = irq; csr_we = we; csr_a = a; csr_di = di;
        #1;
        obs_irq_n = irq_n;
        obs_do    = csr_do;
        check("irq_n_vs_model", {7'b0, irq_n}, {7'b0, m_irq_n});
        check("csr_do_vs_model", csr_do, m_read(a));
        m_step(irq, we, a, di, rst);
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    endtask

    task automatic strobe();
        tick(1'b1, 1'b0, 5'd0, 8'h00, 1'b1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        tick(1'b0, 1'b1, a, d, 1'b1);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
        tick(1'b0, 1'b0, a, 8'h00, 1'b1);
        check(tag, obs_do, exp);
    endtask

    initial begin
        int   low;
        bit   seq[$];
        int   runs[$];
        int   run;
        bit   irq_r, we_r, rst_r;
        logic [4:0] a_r;
        logic [7:0] d_r;

        repeat (2) @(posedge clk);

        // Reset values and a default 16-cycle pulse.
        rd(5'd0, 8'h00, "rst_ctrl");
        check("rst_irq_n", {7'b0, obs_irq_n}, 8'h01);
        rd(5'd1, 8'h0F, "rst_width");
        rd(5'd2, 8'h00, "rst_holdoff");
        rd(5'd3, 8'h00, "rst_miss");
        wr(5'd0, 8'h01);
        strobe();
        rd(5'd0, 8'h81, "pulse_ctrl");
        check("latency", {7'b0, obs_irq_n}, 8'h00);
        low = 1;
        for (int i = 0; i < 40; i++) begin
            idle_tick();
            if (obs_irq_n == 1'b0) low++;
            else break;
        end
        check("pulse16_len", 8'(low), 8'd16);
        check("ctrl_after", obs_do, 8'h01);

        // Merged re-assertion with a hold-off gap.
        wr(5'd1, 8'd3);
        wr(5'd2, 8'd5);
        wr(5'd3, 8'h00);
        strobe();
        for (int i = 0; i < 3; i++) begin
            strobe();
            seq.push_back(obs_irq_n);
        end
        for (int i = 0; i < 25; i++) begin
            idle_tick();
            seq.push_back(obs_irq_n);
        end
        run = 1;
        for (int i = 1; i < seq.size(); i++) begin
            if (seq[i] == seq[i-1]) run++;
            else begin
                runs.push_back(run);
                run = 1;
            end
        end
        runs.push_back(run);
        check("merge_nruns", 8'(runs.size()), 8'd4);
        if (runs.size() >= 3) begin
            check("merge_pulse1", 8'(runs[0]), 8'd4);
            check("merge_gap", 8'(runs[1]), 8'd5);
            check("merge_pulse2", 8'(runs[2]), 8'd4);
        end
        rd(5'd3, 8'd3, "merge_miss");
        rd(5'd0, 8'h01, "merge_pend_clear");

        // Level mode held until acknowledge.
        wr(5'd0, 8'h03);
        strobe();
        low = 0;
        for (int i = 0; i < 100; i++) begin
            idle_tick();
            if (obs_irq_n == 1'b0) low++;
        end
        check("level_held", 8'(low), 8'd100);
        wr(5'd0, 8'h83);
        idle_tick();
        check("ack_deassert", {7'b0, obs_irq_n}, 8'h01);
        repeat (8) idle_tick();
        wr(5'd0, 8'h83);
        idle_tick();
        check("idle_ack_ignored", {7'b0, obs_irq_n}, 8'h01);
        rd(5'd0, 8'h03, "idle_ack_ctrl");

        // Miss saturation, then clear coincident with a strobe.
        wr(5'd3, 8'h00);
        strobe();
        repeat (300) strobe();
        rd(5'd3, 8'hFF, "miss_sat");
        tick(1'b1, 1'b1, 5'd3, 8'h00, 1'b1);
        rd(5'd3, 8'h01, "miss_clr_inc");
        rd(5'd0, 8'hC3, "level_pend_stat");
        tick(1'b1, 1'b1, 5'd0, 8'h83, 1'b1);
        rd(5'd0, 8'h43, "ack_irq_pend");
        wr(5'd0, 8'h00);
        repeat (3) idle_tick();

        // Disable mid-pulse.
        wr(5'd2, 8'h00);
        wr(5'd1, 8'h0F);
        wr(5'd0, 8'h01);
        strobe();
        repeat (3) idle_tick();
        strobe();
        wr(5'd0, 8'h00);
        idle_tick();
        check("en0_still_low", {7'b0, obs_irq_n}, 8'h00);
        idle_tick();
        check("en0_next_edge", {7'b0, obs_irq_n}, 8'h01);
        rd(5'd0, 8'h00, "en0_pend_clear");
        strobe();
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            check("en0_ignored", {7'b0, obs_irq_n}, 8'h01);
        end

        // Reset mid-pulse.
        wr(5'd1, 8'h40);
        wr(5'd2, 8'h07);
        wr(5'd0, 8'h01);
        strobe();
        repeat (5) idle_tick();
        tick(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
        idle_tick();
        check("rst_mid_irq_n", {7'b0, obs_irq_n}, 8'h01);
        rd(5'd0, 8'h00, "rst_mid_ctrl");
        rd(5'd1, 8'h0F, "rst_mid_width");
        rd(5'd2, 8'h00, "rst_mid_holdoff");
        rd(5'd3, 8'h00, "rst_mid_miss");
        rd(5'h10, 8'h00, "undecoded");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            irq_r = ($urandom_range(5) == 0);
            we_r  = ($urandom_range(11) == 0);
            rst_r = ($urandom_range(799) != 0);
            a_r   = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(3));
            if (a_r == 5'd1 || a_r == 5'd2) d_r = 8'($urandom_range(7));
            else if (a_r == 5'd0 && $urandom_range(3) != 0) d_r = 8'($urandom) | 8'h01;
            else d_r = 8'($urandom);
            tick(irq_r, we_r, a_r, d_r, rst_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_out.md
# irq_out

Output stage for the interrupt controller: takes its one-cycle `irq` strobe and drives the board's active-low interrupt line toward the SoC. It supports a pulse mode with programmable width, or a level mode held until software acknowledges. A programmable hold-off enforces a minimum deasserted gap between assertions. Strobes arriving while busy are merged into one pending re-assertion and counted. It sits on the same 5-bit/8-bit CSR bus as the other CPLD blocks.

## Interface
- `BASE_ADDR`, 5'h0, CSR base; block decodes `BASE_ADDR+0..+3`
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `csr_a`  in  5  CSR address
- `csr_di`  in  8  CSR write data
- `csr_we`  in  1  CSR write strobe, one cycle per write
- `csr_do`  out  8  CSR read data, combinational mux; 8'h00 for non-decoded addresses
- `irq_in`  in  1  interrupt strobe from the interrupt controller, synchronous to `clk`
- `irq_n`  out  1  registered active-low interrupt output

## Operation
- Registers:
  - +0 CTRL: bit0 EN (rw); bit1 MODE (rw, 0 = pulse, 1 = level); bit6 PEND (ro); bit7 STAT (ro, 1 while ASSERT). Writing bit7=1 is the level-mode acknowledge. Bits 5:2 read 0.
  - +1 WIDTH: rw, reset 8'h0F. In pulse mode a pulse lasts WIDTH+1 cycles.
  - +2 HOLDOFF: rw, reset 8'h00. Minimum deasserted gap is max(HOLDOFF,1) cycles.
  - +3 MISS: ro, 8-bit saturating at 8'hFF. Any write clears it.
- State machine: IDLE, ASSERT, HOLDOFF. An 8-bit down-counter `cnt` serves both timed states.
- IDLE: `irq_n`=1. If EN and (`irq_in` or PEND), go to ASSERT with `cnt`<=WIDTH and `irq_n`<=0, and clear PEND.
- ASSERT, pulse mode: if `cnt`==0, exit; otherwise `cnt`--.
- ASSERT, level mode: stay until a CTRL write with bit7=1, then exit. `cnt` is unused.
- Exit from ASSERT: `irq_n`<=1. If HOLDOFF==0, go to IDLE. Otherwise go to HOLDOFF with `cnt`<=HOLDOFF-1.
- HOLDOFF: if `cnt`==0, go to ASSERT if EN and PEND (reload WIDTH, clear PEND, `irq_n`<=0), else to IDLE. Otherwise `cnt`--.
- `irq_in` in ASSERT or HOLDOFF: PEND<=1 and MISS increments (saturating).
- EN=0: `irq_in` ignored, PEND cleared. In ASSERT or HOLDOFF, go to IDLE on the next edge with `irq_n`<=1. MISS is held.
- A level-mode acknowledge outside ASSERT, or while MODE=0, is ignored.
- MODE changes take effect on the next cycle's evaluation. Switching level→pulse mid-assert exits when `cnt` reaches 0, counting down from its entry value.
- WIDTH and HOLDOFF writes affect only the next load of `cnt`.

## Timing
- Reset values: `irq_n`=1, IDLE, CTRL=8'h00, WIDTH=8'h0F, HOLDOFF=8'h00, MISS=8'h00, PEND=0, `cnt`=0. `csr_do` follows the register values.
- Latency: `irq_in` high at edge N (IDLE, EN=1) gives `irq_n` low at edge N, visible in cycle N+1.
- Pulse length: exactly WIDTH+1 cycles. WIDTH=0 gives a 1-cycle pulse.
- Merged re-assert: `irq_n` stays high for exactly max(HOLDOFF,1) cycles between pulses.
- Level-mode acknowledge written at edge M: `irq_n` high from edge M.
- Simultaneous MISS-clear write and `irq_in` while busy: MISS=1 (the clear applies first, then the increment).
- Simultaneous acknowledge and `irq_in` in level mode: deassert, and PEND=1.
- `rst_n` low mid-assert: next edge restores all reset values and `irq_n`=1.
- CSR writes take effect at the edge where `csr_we`=1. Reads reflect the new value from the next cycle.

## Test plan
- Reset, write CTRL=8'h01, one `irq_in` strobe → `irq_n` low for 16 cycles starting the cycle after the strobe; CTRL reads 8'h81 during the pulse, 8'h01 after.
- WIDTH=3, HOLDOFF=5, three strobes during the pulse → pulse of 4, high gap of 5, second pulse of 4; MISS=3; PEND=0 at the end.
- MODE=1 (CTRL=8'h03), strobe → `irq_n` held low for 100 cycles; write CTRL=8'h83 → high on the same edge; an acknowledge while idle has no effect.
- 300 strobes while held in level mode → MISS=8'hFF; write +3 on the same cycle as a strobe → MISS=1.
- CTRL=8'h00 mid-pulse → `irq_n`=1 on the next edge, PEND=0, and later strobes are ignored.
- `rst_n` low for 1 cycle mid-pulse with WIDTH=8'h40 → `irq_n`=1, all registers at reset values, `csr_do` at an undecoded address = 8'h00.
